// File: rtl/ipg_tx_inserter_pkg.sv
// Shared block-level constants and helpers for the IPG memory-reply inserter.
// Covers the 64b/66b sync headers, the IDLE control block, and the selection enum.
package ipg_tx_inserter_pkg;

    localparam logic [7:0]  BLK_TYPE_IDLE = 8'h1E;

    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;
    localparam logic [1:0]  SYNC_MEM  = 2'b11;

    localparam logic [63:0] IDLE_DATA = {56'h0, BLK_TYPE_IDLE};

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block_t;

    localparam block_t IDLE_BLOCK = '{hdr: SYNC_CTRL, data: IDLE_DATA};

    typedef enum logic [1:0] {
        SEL_FWD,
        SEL_MEM,
        SEL_IDLE
    } sel_e;

    // An IDLE block is exactly the all-idle control block; any other payload is frame traffic.
    function automatic logic isIdleBlock(input logic [1:0] hdr, input logic [63:0] data);
        return (hdr == SYNC_CTRL) && (data[7:0] == BLK_TYPE_IDLE) && (data[63:8] == 56'h0);
    endfunction

endpackage

// File: rtl/ipg_memq_fifo.sv
// Synchronous FIFO for memory-reply chunks: registered storage, combinational head.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module ipg_memq_fifo
    import ipg_tx_inserter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wrPtr;
    logic [AW:0]           r_rdPtr;
    logic                  w_doPush;
    logic                  w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ipg_tx_inserter.sv
// Transmit-path inserter: forwards encoded blocks, filling idle gaps with queued memory-reply chunks.
// Frame blocks always win; the output is registered with one cycle of latency.
module ipg_tx_inserter
    import ipg_tx_inserter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int MEMQ_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  netq_write,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    input  logic                  memq_write,
    input  logic [DATA_WIDTH-1:0] ipg_reply_chunk,
    input  logic                  tx_pause,
    output logic [DATA_WIDTH-1:0] proced_encoded_tx_data,
    output logic [HDR_WIDTH-1:0]  proced_encoded_tx_hdr
);

    logic [DATA_WIDTH-1:0] w_memHead;
    logic                  w_memFull;
    logic                  w_memEmpty;
    logic                  w_inIsIdle;
    logic                  w_eligible;
    logic                  w_pop;
    sel_e                  w_sel;

    ipg_memq_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMQ_DEPTH)
    ) u_memq (
        .clk     (clk),
        .reset   (reset),
        .i_push  (memq_write),
        .i_data  (ipg_reply_chunk),
        .i_pop   (w_pop),
        .o_head  (w_memHead),
        .o_full  (w_memFull),
        .o_empty (w_memEmpty)
    );

    assign w_inIsIdle = isIdleBlock(encoded_tx_hdr, encoded_tx_data);
    assign w_eligible = !netq_write || w_inIsIdle;

    always_comb begin
        w_sel = SEL_IDLE;
        w_pop = 1'b0;
        if (netq_write && !w_inIsIdle) begin
            w_sel = SEL_FWD;
        end else if (w_eligible && !w_memEmpty && !tx_pause) begin
            w_sel = SEL_MEM;
            w_pop = 1'b1;
        end else if (netq_write) begin
            w_sel = SEL_FWD;
        end
    end

    // Full is only consumed inside the FIFO; the top just needs the flag to exist for observability.
    logic w_unusedFull;
    assign w_unusedFull = w_memFull;

    always_ff @(posedge clk) begin
        if (reset) begin
            proced_encoded_tx_hdr  <= IDLE_BLOCK.hdr;
            proced_encoded_tx_data <= IDLE_BLOCK.data;
        end else begin
            case (w_sel)
                SEL_FWD: begin
                    proced_encoded_tx_hdr  <= encoded_tx_hdr;
                    proced_encoded_tx_data <= encoded_tx_data;
                end
                SEL_MEM: begin
                    proced_encoded_tx_hdr  <= SYNC_MEM;
                    proced_encoded_tx_data <= w_memHead;
                end
                default: begin
                    proced_encoded_tx_hdr  <= IDLE_BLOCK.hdr;
                    proced_encoded_tx_data <= IDLE_BLOCK.data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipg_tx_inserter.sv
// Self-checking bench for ipg_tx_inserter against a queue-based behavioural model.
// Directed scenarios plus a randomized mixed-traffic run, one task per scenario.
module tb_ipg_tx_inserter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        netq_write;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic        memq_write;
    logic [63:0] ipg_reply_chunk;
    logic        tx_pause;
    logic [63:0] proced_encoded_tx_data;
    logic [1:0]  proced_encoded_tx_hdr;

    int          testCount = 0;
    int          failCount = 0;
    logic [63:0] modelQ[$];
    logic [63:0] expData;
    logic [1:0]  expHdr;

    ipg_tx_inserter #(
        .DATA_WIDTH (64),
        .HDR_WIDTH  (2),
        .MEMQ_DEPTH (DEPTH)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .netq_write             (netq_write),
        .encoded_tx_data        (encoded_tx_data),
        .encoded_tx_hdr         (encoded_tx_hdr),
        .memq_write             (memq_write),
        .ipg_reply_chunk        (ipg_reply_chunk),
        .tx_pause               (tx_pause),
        .proced_encoded_tx_data (proced_encoded_tx_data),
        .proced_encoded_tx_hdr  (proced_encoded_tx_hdr)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs and advances the reference model by the same edge.
    task automatic drive(input logic rst, input logic nw, input logic [63:0] d, input logic [1:0] h,
                         input logic mw, input logic [63:0] c, input logic pause);
        int  sizeBefore;
        logic isIdle;
        @(negedge clk);
        reset           = rst;
        netq_write      = nw;
        encoded_tx_data = d;
        encoded_tx_hdr  = h;
        memq_write      = mw;
        ipg_reply_chunk = c;
        tx_pause        = pause;
        @(posedge clk);
        if (rst) begin
            modelQ.delete();
            expHdr  = 2'b10;
            expData = 64'h1E;
        end else begin
            sizeBefore = modelQ.size();
            isIdle = (h == 2'b10) && (d == 64'h1E);
            if (nw && !isIdle) begin
                expHdr  = h;
                expData = d;
            end else if (sizeBefore > 0 && !pause) begin
                expHdr  = 2'b11;
                expData = modelQ.pop_front();
            end else if (nw) begin
                expHdr  = h;
                expData = d;
            end else begin
                expHdr  = 2'b10;
                expData = 64'h1E;
            end
            if (mw && sizeBefore < DEPTH) modelQ.push_back(c);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom),
                  {$urandom, $urandom}, 1'($urandom));
            testCount++;
            if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
                failCount++;
                $display("[TB] FAIL reset_hold[%0d]: got hdr=%b data=%h, expected hdr=10 data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
            end
        end
        drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
        testCount++;
        if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
            failCount++;
            $display("[TB] FAIL reset_release: got hdr=%b data=%h, expected hdr=10 data=%h",
                     proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 64'h1111_0000_0000_0000 + 64'(i), 2'b01, 1'b1,
                  64'hB000_0000_0000_0000 + 64'(i), 1'b0);
        end
        drive(1'b0, 1'b1, 64'hDEADBEEF01234567, 2'b01, 1'b0, 64'h0, 1'b0);
        testCount++;
        if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b01, 64'hDEADBEEF01234567}) begin
            failCount++;
            $display("[TB] FAIL passthrough: got hdr=%b data=%h, expected hdr=01 data=deadbeef01234567",
                     proced_encoded_tx_hdr, proced_encoded_tx_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
            testCount++;
            if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {expHdr, expData} ||
                (i < 3 && expData !== 64'hB000_0000_0000_0000 + 64'(i))) begin
                failCount++;
                $display("[TB] FAIL passthrough_drain[%0d]: got hdr=%b data=%h, expected hdr=%b data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, expHdr, expData);
            end
        end
    endtask

    task automatic test_insertion();
        drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 64'hA5A5_0000_1111_2222, 1'b0);
        testCount++;
        if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
            failCount++;
            $display("[TB] FAIL no_write_through: got hdr=%b data=%h, expected hdr=10 data=%h",
                     proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
        end
        drive(1'b0, 1'b1, 64'h1E, 2'b10, 1'b0, 64'h0, 1'b0);
        testCount++;
        if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b11, 64'hA5A5_0000_1111_2222}) begin
            failCount++;
            $display("[TB] FAIL insertion: got hdr=%b data=%h, expected hdr=11 data=a5a5000011112222",
                     proced_encoded_tx_hdr, proced_encoded_tx_data);
        end
        drive(1'b0, 1'b1, 64'h1E, 2'b10, 1'b0, 64'h0, 1'b0);
        testCount++;
        if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
            failCount++;
            $display("[TB] FAIL insertion_next_idle: got hdr=%b data=%h, expected hdr=10 data=%h",
                     proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
        end
    endtask

    task automatic test_pause();
        drive(1'b0, 1'b1, 64'h0123, 2'b01, 1'b1, 64'hCAFE_0000_0000_0001, 1'b0);
        drive(1'b0, 1'b1, 64'h0456, 2'b01, 1'b1, 64'hCAFE_0000_0000_0002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'(i % 2), 64'h1E, 2'b10, 1'b0, 64'h0, 1'b1);
            testCount++;
            if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
                failCount++;
                $display("[TB] FAIL pause_idle[%0d]: got hdr=%b data=%h, expected hdr=10 data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
            testCount++;
            if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b11, 64'hCAFE_0000_0000_0001 + 64'(i)}) begin
                failCount++;
                $display("[TB] FAIL pause_release[%0d]: got hdr=%b data=%h, expected hdr=11 data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, 64'hCAFE_0000_0000_0001 + 64'(i));
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(1'b0, 1'b1, {$urandom, $urandom}, 2'b01, 1'b1, 64'hF000_0000_0000_0000 + 64'(i), 1'b0);
        end
        // A push into a full queue is dropped even though this cycle also pops.
        drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
            testCount++;
            if (i < DEPTH) begin
                if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b11, 64'hF000_0000_0000_0000 + 64'(i)}) begin
                    failCount++;
                    $display("[TB] FAIL overflow_drain[%0d]: got hdr=%b data=%h, expected hdr=11 data=%h",
                             i, proced_encoded_tx_hdr, proced_encoded_tx_data, 64'hF000_0000_0000_0000 + 64'(i));
                end
            end else if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
                failCount++;
                $display("[TB] FAIL overflow_extra[%0d]: got hdr=%b data=%h, expected hdr=10 data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] want;
        for (int i = 0; i <= 3 * DEPTH; i++) begin
            drive(1'b0, 1'b0, 64'h0, 2'b00, 1'(i < 3 * DEPTH), 64'h7700_0000_0000_0000 + 64'(i), 1'b0);
            want = 64'h7700_0000_0000_0000 + 64'(i - 1);
            testCount++;
            if (i == 0) begin
                if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b10, 64'h1E}) begin
                    failCount++;
                    $display("[TB] FAIL stream_first: got hdr=%b data=%h, expected hdr=10 data=%h",
                             proced_encoded_tx_hdr, proced_encoded_tx_data, 64'h1E);
                end
            end else if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {2'b11, want}) begin
                failCount++;
                $display("[TB] FAIL stream[%0d]: got hdr=%b data=%h, expected hdr=11 data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, want);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [1:0]  h;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: begin h = 2'b10; d = 64'h1E; end
                1: begin h = 2'b01; d = {$urandom, $urandom}; end
                2: begin h = 2'b10; d = 64'h1E | (64'h1 << $urandom_range(8, 63)); end
                3: begin h = 2'b10; d = {$urandom, $urandom}; end
                default: begin h = 2'($urandom_range(0, 1) * 3); d = {$urandom, $urandom}; end
            endcase
            drive(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)), d, h,
                  1'($urandom_range(0, 99) < 45), {$urandom, $urandom}, 1'($urandom_range(0, 99) < 20));
            testCount++;
            if ({proced_encoded_tx_hdr, proced_encoded_tx_data} !== {expHdr, expData}) begin
                failCount++;
                $display("[TB] FAIL random[%0d]: got hdr=%b data=%h, expected hdr=%b data=%h",
                         i, proced_encoded_tx_hdr, proced_encoded_tx_data, expHdr, expData);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        netq_write = 1'b0;
        encoded_tx_data = '0;
        encoded_tx_hdr = '0;
        memq_write = 1'b0;
        ipg_reply_chunk = '0;
        tx_pause = 1'b0;
        test_reset();
        test_passthrough();
        test_insertion();
        test_pause();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
